mdu: RTL and testbench

Multiply/divide unit in the EX stage, beside the ALU. It consumes the same forwarded operands A/B from the ID/EX register and executes mult/multu/div/divu over multiple cycles into architectural HI/LO registers. It serves mthi/mtlo writes and mfhi/mflo reads, whose result the EX-stage result mux selects alongside the ALU output. It exports a busy flag that the hazard unit uses to stall md-class instructions in ID.

---
 rtl/mdu_pkg.sv | 11 +
 rtl/mdu_if.sv | 12 +
 rtl/mdu.sv | 82 ++++++++
 tb/tb_mdu.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and decode helper for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [3:0] {
    mdu_none, mdu_mult, mdu_multu, mdu_div, mdu_divu,
    mdu_mfhi, mdu_mflo, mdu_mthi, mdu_mtlo
  } mdu_op_e;
  typedef enum logic {st_idle, st_run} mdu_state_e;
  function automatic logic is_md(mdu_op_e op);
    return op inside {mdu_mult, mdu_multu, mdu_div, mdu_divu};
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage operand/op bundle into the mdu and busy/read result back out
interface mdu_if;
  import mdu_pkg::*;
  logic start;
  mdu_op_e mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic busy;
  logic [31:0] out;
  modport master (output start, mdu_op, A, B, input busy, out);
  modport slave (input start, mdu_op, A, B, output busy, out);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle mult/div into HI/LO with mthi/mtlo writes and mfhi/mflo reads
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave m
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  mdu_state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hi, lo, pend_hi, pend_lo, hi_n, lo_n, pend_hi_n, pend_lo_n;
  logic pend_wr, pend_wr_n, launch, is_div, ovf;
  logic [63:0] prod_s, prod_u;
  logic [31:0] bs_s, bs_u, qu, ru;
  logic signed [31:0] qs, rs;
  assign prod_s = $signed({{32{m.A[31]}}, m.A}) * $signed({{32{m.B[31]}}, m.B});
  assign prod_u = {32'b0, m.A} * {32'b0, m.B};
  // Divisor forced to 1 for /0 (result discarded) and for INT_MIN/-1, where A/1 is the wrapped answer
  assign ovf = m.A == 32'h8000_0000 && m.B == 32'hffff_ffff;
  assign bs_s = (m.B == 32'b0 || ovf) ? 32'd1 : m.B;
  assign bs_u = m.B == 32'b0 ? 32'd1 : m.B;
  assign qs = $signed(m.A) / $signed(bs_s);
  assign rs = $signed(m.A) % $signed(bs_s);
  assign qu = m.A / bs_u;
  assign ru = m.A % bs_u;
  assign m.busy = st == st_run;
  assign m.out = m.mdu_op == mdu_mfhi ? hi : m.mdu_op == mdu_mflo ? lo : 32'b0;
  always_comb begin
    launch = m.start && st == st_idle && is_md(m.mdu_op);
    is_div = m.mdu_op inside {mdu_div, mdu_divu};
    st_n = st;
    cnt_n = cnt;
    hi_n = hi;
    lo_n = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    if (st == st_idle) begin
      if (launch) begin
        st_n = st_run;
        cnt_n = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        pend_wr_n = !(is_div && m.B == 32'b0);
        {pend_hi_n, pend_lo_n} = m.mdu_op == mdu_mult ? prod_s :
                                 m.mdu_op == mdu_multu ? prod_u :
                                 m.mdu_op == mdu_div ? {rs, qs} : {ru, qu};
      end else begin
        hi_n = m.mdu_op == mdu_mthi ? m.A : hi;
        lo_n = m.mdu_op == mdu_mtlo ? m.A : lo;
      end
    end else if (cnt == CW'(1)) begin
      st_n = st_idle;
      cnt_n = '0;
      hi_n = pend_wr ? pend_hi : hi;
      lo_n = pend_wr ? pend_lo : lo;
    end else begin
      cnt_n = cnt - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= st_idle;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      hi <= hi_n;
      lo <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors against a cycle-stamped HI/LO model of the mdu
module tb_mdu;
  import mdu_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0;
  logic reset = 0;
  mdu_if bus();
  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int cyc, done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit p_wr;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Model: an operation launched at edge number e commits at edge e+N; busy while cyc < done
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; cyc = 0; done = 0; p_wr = 0;
    end else begin
      automatic bit was_busy = cyc < done;
      automatic int ia = bus.A;
      automatic int ib = bus.B;
      cyc = cyc + 1;
      if (was_busy) begin
        if (cyc == done && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (bus.start && is_md(bus.mdu_op)) begin
        p_wr = 1;
        case (bus.mdu_op)
          mdu_mult: {p_hi, p_lo} = longint'(ia) * longint'(ib);
          mdu_multu: {p_hi, p_lo} = {32'b0, bus.A} * {32'b0, bus.B};
          mdu_div:
            if (ib == 0) p_wr = 0;
            else if (bus.A == 32'h8000_0000 && ib == -1) begin p_lo = bus.A; p_hi = 0; end
            else begin p_lo = ia / ib; p_hi = ia % ib; end
          default:
            if (ib == 0) p_wr = 0;
            else begin p_lo = bus.A / bus.B; p_hi = bus.A % bus.B; end
        endcase
        done = cyc + ((bus.mdu_op inside {mdu_div, mdu_divu}) ? DC : MC);
      end else if (bus.mdu_op == mdu_mthi) m_hi = bus.A;
      else if (bus.mdu_op == mdu_mtlo) m_lo = bus.A;
    end
  end
  always @(negedge clk) begin
    check("busy", {31'b0, bus.busy}, {31'b0, cyc < done});
    check("out", bus.out, bus.mdu_op == mdu_mfhi ? m_hi : bus.mdu_op == mdu_mflo ? m_lo : 32'b0);
  end
  task automatic drive(logic s, mdu_op_e op, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #1;
    bus.start = s; bus.mdu_op = op; bus.A = a; bus.B = b;
  endtask
  task automatic read(mdu_op_e op, logic [31:0] exp, string name);
    drive(0, op, 0, 0);
    #2 check(name, bus.out, exp);
  endtask
  task automatic run(mdu_op_e op, logic [31:0] a, logic [31:0] b, int n_exp, logic [31:0] old_lo,
                     logic [31:0] exp_hi, logic [31:0] exp_lo, string name);
    int n = 0;
    drive(1, op, a, b);
    drive(0, mdu_mflo, 0, 0);
    #2 check({name, "_old_lo"}, bus.out, old_lo);
    while (bus.busy && n < 40) begin n++; @(posedge clk); #1; end
    check({name, "_busy_len"}, n, n_exp);
    read(mdu_mfhi, exp_hi, {name, "_hi"});
    read(mdu_mflo, exp_lo, {name, "_lo"});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin n++; @(posedge clk); #1; end
    check("idle_timeout", {31'b0, bus.busy}, 32'b0);
  endtask
  initial begin
    bus.start = 0; bus.mdu_op = mdu_none; bus.A = 0; bus.B = 0;
    repeat (4) drive(1, mdu_op_e'($urandom_range(0, 8)), $urandom, $urandom);
    drive(0, mdu_mfhi, 0, 0);
    #2 check("rst_busy", {31'b0, bus.busy}, 32'b0);
    check("rst_hi", bus.out, 32'h0);
    bus.mdu_op = mdu_mflo;
    #1 check("rst_lo", bus.out, 32'h0);
    @(posedge clk); #1 reset = 1;
    drive(0, mdu_mthi, 32'h1234_5678, 0);
    read(mdu_mfhi, 32'h1234_5678, "mthi");
    drive(0, mdu_mtlo, 32'h1111_1111, 0);
    run(mdu_mult, 32'd3, 32'hffff_fffe, MC, 32'h1111_1111, 32'hffff_ffff, 32'hffff_fffa, "mult");
    run(mdu_multu, 32'hffff_ffff, 32'hffff_ffff, MC, 32'hffff_fffa, 32'hffff_fffe, 32'h1, "multu");
    run(mdu_div, 32'hffff_fff9, 32'd2, DC, 32'h1, 32'hffff_ffff, 32'hffff_fffd, "div");
    drive(0, mdu_mthi, 32'haaaa, 0);
    drive(0, mdu_mtlo, 32'h5555, 0);
    run(mdu_divu, 32'd7, 32'd0, DC, 32'h5555, 32'haaaa, 32'h5555, "divu0");
    run(mdu_div, 32'h8000_0000, 32'hffff_ffff, DC, 32'h5555, 32'h0, 32'h8000_0000, "divovf");
    drive(1, mdu_div, 32'd100, 32'd7);
    drive(1, mdu_mult, 32'd5, 32'd5);
    drive(0, mdu_mtlo, 32'hbeef, 0);
    drive(0, mdu_none, 0, 0);
    wait_idle();
    read(mdu_mfhi, 32'd2, "ign_hi");
    read(mdu_mflo, 32'd14, "ign_lo");
    drive(1, mdu_div, 32'd9, 32'd2);
    repeat (3) drive(0, mdu_none, 0, 0);
    reset = 0;
    bus.mdu_op = mdu_mfhi;
    #1 check("abort_busy", {31'b0, bus.busy}, 32'b0);
    check("abort_hi", bus.out, 32'h0);
    bus.mdu_op = mdu_mflo;
    #1 check("abort_lo", bus.out, 32'h0);
    @(posedge clk); #1 reset = 1;
    repeat (12) drive(0, mdu_none, 0, 0);
    read(mdu_mflo, 32'h0, "abort_lo_late");
    read(mdu_mfhi, 32'h0, "abort_hi_late");
    drive(0, mdu_none, 0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
